// File: rtl/write_demux_1_32_if.sv
// Write-port bundle between the write-back stage, write_demux_1_32 and the
// register file: upstream valid/ready write request, downstream one-hot
// enable/data, and the buffer occupancy.
interface write_demux_1_32_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    localparam int NUM_REG = 2 ** ADDR_W;

    logic                in_valid;
    logic                in_ready;
    logic [ADDR_W-1:0]   in_addr;
    logic [DATA_W-1:0]   in_data;
    logic                out_valid;
    logic                out_ready;
    logic [NUM_REG-1:0]  out_en;
    logic [ADDR_W-1:0]   out_addr;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          occupancy;

    // Write-back stage / register-file side that drives requests and consumes heads
    modport master (
        output in_valid, in_addr, in_data, out_ready,
        input  in_ready, out_valid, out_en, out_addr, out_data, occupancy
    );

    // Demultiplexer side
    modport slave (
        input  in_valid, in_addr, in_data, out_ready,
        output in_ready, out_valid, out_en, out_addr, out_data, occupancy
    );
endinterface

// File: rtl/write_demux_1_32.sv
// Register-file write-port demultiplexer: a two-entry skid buffer (main/skid)
// whose head drives a one-hot write-enable vector plus address and data.
// in_ready is decoded from registered state only, so there is no
// combinational path from out_ready to in_ready.
// Optional feature macro: WRITE_DEMUX_ZERO_REG_EN -- when defined, the top
// register (X31/XZR) never gets a write enable, although the transaction is
// still buffered and drained with normal handshake timing.
module write_demux_1_32 #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    write_demux_1_32_if.slave bus
);
    localparam int NUM_REG = 2 ** ADDR_W;

    // EMPTY: nothing buffered; ONE: main valid; FULL: main and skid valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              main_vld;
    logic              skid_vld;
    logic              accept;
    logic              drain;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic [ADDR_W-1:0] main_addr;
    logic [DATA_W-1:0] main_data;
    logic [ADDR_W-1:0] skid_addr;
    logic [DATA_W-1:0] skid_data;

    // One-hot decode of the head address, gated by head valid. The enable is
    // a shallow function of registered state only, so it settles early in the
    // cycle and the register file samples it at the following edge.
    function automatic logic [NUM_REG-1:0] decode_en(input logic              vld,
                                                     input logic [ADDR_W-1:0] addr);
        logic [NUM_REG-1:0] en;
        en = '0;
        if (vld) begin
            en[addr] = 1'b1;
        end
`ifdef WRITE_DEMUX_ZERO_REG_EN
        if (&addr) begin
            en = '0;
        end
`endif
        return en;
    endfunction

    assign main_vld = (state != ST_EMPTY);
    assign skid_vld = (state == ST_FULL);
    assign accept   = bus.in_valid & ~skid_vld;
    assign drain    = main_vld & bus.out_ready;

    // Buffer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and entry load enables from accept/drain
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_nxt    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = ST_FULL;
                end else if (drain) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ST_ONE;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Main (head) entry; keeps its contents after draining so out_data holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_addr <= '0;
            main_data <= '0;
        end else if (load_main_in) begin
            main_addr <= bus.in_addr;
            main_data <= bus.in_data;
        end else if (load_main_skid) begin
            main_addr <= skid_addr;
            main_data <= skid_data;
        end
    end

    // Skid entry captures the input only when the head is stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_addr <= '0;
            skid_data <= '0;
        end else if (load_skid) begin
            skid_addr <= bus.in_addr;
            skid_data <= bus.in_data;
        end
    end

    assign bus.in_ready  = ~skid_vld;
    assign bus.out_valid = main_vld;
    assign bus.out_addr  = main_addr;
    assign bus.out_data  = main_data;
    assign bus.out_en    = decode_en(main_vld, main_addr);
    assign bus.occupancy = {1'b0, main_vld} + {1'b0, skid_vld};

endmodule

// File: tb/tb_write_demux_1_32.sv
// Testbench for write_demux_1_32: directed scenarios plus random traffic,
// checked by a FIFO scoreboard of accepted write transactions.
module tb_write_demux_1_32;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } txn_t;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    txn_t q[$];
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_data;

    write_demux_1_32_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    write_demux_1_32 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected enable for a head transaction
    function automatic logic [31:0] exp_en(input logic [ADDR_W-1:0] a);
`ifdef WRITE_DEMUX_ZERO_REG_EN
        if (a == 5'd31) return 32'h0;
`endif
        return 32'h1 << a;
    endfunction

    // Reference model: a FIFO of at most two accepted transactions
    always @(posedge clk or negedge reset_n) begin
        bit   acc;
        bit   drn;
        txn_t t;
        if (!reset_n) begin
            q.delete();
            last_addr = '0;
            last_data = '0;
        end else begin
            acc = bus.in_valid && (q.size() < 2);
            drn = bus.out_ready && (q.size() > 0);
            if (drn) begin
                t = q.pop_front();
                last_addr = t.addr;
                last_data = t.data;
            end
            if (acc) begin
                t.addr = bus.in_addr;
                t.data = bus.in_data;
                q.push_back(t);
            end
        end
    end

    // Monitor: compare DUT outputs with the scoreboard head on the falling edge
    always @(negedge clk) begin
        if (reset_n) begin
            chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
            chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
            if (q.size() > 0) begin
                chk("out_en", 64'(bus.out_en), 64'(exp_en(q[0].addr)));
                chk("out_addr", 64'(bus.out_addr), 64'(q[0].addr));
                chk("out_data", bus.out_data, q[0].data);
            end else begin
                chk("idle_out_en", 64'(bus.out_en), 64'h0);
                chk("idle_out_addr", 64'(bus.out_addr), 64'(last_addr));
                chk("idle_out_data", bus.out_data, last_data);
            end
        end
    end

    // One cycle of stimulus, applied just after the falling edge
    task automatic drive(input logic v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic r);
        @(negedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_addr   = a;
        bus.in_data   = d;
        bus.out_ready = r;
    endtask

    task automatic check_reset_state();
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_out_en", 64'(bus.out_en), 64'h0);
        chk("rst_out_addr", 64'(bus.out_addr), 64'h0);
        chk("rst_out_data", bus.out_data, 64'h0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'h0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset_n       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        // Streaming at full throughput
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, ADDR_W'(i), DATA_W'(i) * 64'h1111, 1'b1);
        end
        drive(1'b0, '0, '0, 1'b1);

        // Backpressure: 3 and 7 fill the buffer, 9 waits until space opens
        drive(1'b1, 5'd3, 64'h3333, 1'b0);
        drive(1'b1, 5'd7, 64'h7777, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 5'd9, 64'h9999, 1'b0);
        drive(1'b1, 5'd9, 64'h9999, 1'b1);
        drive(1'b1, 5'd9, 64'h9999, 1'b1);
        drive(1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 1'b1);

        // Simultaneous accept and drain at occupancy 1
        drive(1'b1, 5'd5, 64'h5555, 1'b0);
        drive(1'b1, 5'd6, 64'h6666, 1'b1);
        drive(1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b1);

        // Zero register
        drive(1'b1, 5'd31, 64'hDEAD, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b1);

        // Idle: out_data must hold its last value
        for (int i = 0; i < 10; i++) drive(1'b0, '0, '0, 1'(i % 2));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), ADDR_W'($urandom),
                  {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
        end

        // Reset while both entries are full
        drive(1'b1, 5'd12, 64'hC0FFEE, 1'b0);
        drive(1'b1, 5'd20, 64'hBEEF, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        // A little traffic after reset
        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom_range(0, 1)), ADDR_W'($urandom),
                  {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        drive(1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/write_demux_1_32.md
# write_demux_1_32

Register-file write-port demultiplexer for the pipelined CPU's write-back stage. It accepts one write transaction per cycle through a valid/ready handshake and holds it in a two-entry skid buffer. It presents the buffered transaction to the register file as a one-hot 32-bit write-enable vector plus data. It is the write-side counterpart of the read-port selector tree: that tree selects one of 32 registers onto a bus, and this block steers one bus onto one of 32 registers.

## Interface
- DATA_W, 64: width of write data.
- ADDR_W, 5: register address width; NUM_REG = 2**ADDR_W = 32 enable lines.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream write transaction present.
- in_ready  out  1  block can accept a transaction this cycle.
- in_addr  in  ADDR_W  destination register.
- in_data  in  DATA_W  write data.
- out_valid  out  1  head transaction present.
- out_ready  in  1  register file consumes the head this cycle.
- out_en  out  NUM_REG  one-hot write enable for the head transaction.
- out_addr  out  ADDR_W  head address.
- out_data  out  DATA_W  head data.
- occupancy  out  2  number of buffered entries (0..2).

## Operation
- Storage consists of two registered entries:
  - main: drives out_*.
  - skid: overflow entry.
- Each entry holds a valid bit, an address and data.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- in_ready = !skid.valid. It is a pure register output, with no combinational path from out_ready.
- out_valid = main.valid.
- out_en = one-hot decode of main.addr, gated by main.valid. When main.valid = 0, out_en is all zeros.
- State transitions per edge, written as (main.valid, skid.valid):
  - (0,0), accept: load main → (1,0).
  - (1,0), accept & drain: main replaced by input → (1,0).
  - (1,0), accept & !drain: input loaded into skid → (1,1). in_ready falls.
  - (1,0), drain & !accept → (0,0).
  - (1,1), drain: skid moves to main, skid cleared → (1,0). in_ready rises. No accept is possible in this state.
  - Otherwise: hold.
- Ordering is strict FIFO. No transaction is dropped or duplicated.
- occupancy = main.valid + skid.valid.
- Out-of-range conditions cannot occur: the ADDR_W-bit address always decodes to exactly one line.

## Timing
- Reset (asynchronous, immediate):
  - out_valid = 0, out_en = 0, out_addr = 0, out_data = 0, occupancy = 0, in_ready = 1.
  - Both entries are invalidated, including any transaction in flight when reset asserts.
- Latency: a transaction accepted at edge N is on out_* with out_valid = 1 immediately after edge N.
- Throughput: 1 transaction/cycle while out_ready is held high.
- in_ready deasserts the cycle after the buffer fills. It reasserts the cycle after the drain that empties skid.
- Decode is built from primitives of 50 ps each, with at most 4 inputs per gate and a depth of at most 4 levels. out_en must be settled within 200 ps of the clock edge.
- out_en must be glitch-free relative to the register-file write edge: the register file samples it on the next rising edge only.

## Configuration
- WRITE_DEMUX_ZERO_REG_EN:
  - Defined: address NUM_REG-1 (X31/XZR) never asserts out_en[NUM_REG-1]. out_en is all zeros for that transaction. The transaction is still accepted, occupies the buffer, shows out_valid = 1 and drains normally, so handshake timing is unchanged.
  - Undefined: address 31 decodes like any other and out_en[31] = 1.

## Test plan
- Reset mid-operation: fill both entries, assert reset_n = 0 between edges → out_valid, out_en, occupancy and out_data read 0 immediately and in_ready = 1.
- Streaming: out_ready = 1, send addr 0..30 back-to-back with data = addr × 0x1111 → each cycle out_en = 1 << addr, data matches, occupancy stays 1, in_ready never falls.
- Backpressure: out_ready = 0, send addr 3 then 7 → occupancy = 2 and in_ready = 0 after the second edge. A third offer (addr 9) is not accepted. Raise out_ready → 3, 7, 9 drain in order.
- Simultaneous accept and drain at occupancy 1: head addr 5 draining while addr 6 is offered → next cycle out_en = 0x40, occupancy = 1.
- Zero register: send addr 31, data 0xDEAD → with the macro defined, out_valid = 1 and out_en = 0. Without it, out_en = 0x8000_0000.
- Idle: in_valid = 0 for 10 cycles → out_en = 0, out_valid = 0, and out_data holds its last value.
